// File: rtl/sqrt_pipelined_hs_if.sv
// sqrt_pipelined_hs_if: radicand/result valid-ready bundle.
// master = producer/consumer side, slave = the square-root unit.
interface sqrt_pipelined_hs_if #(
    parameter int INPUT_BITS = 16,
    parameter int FRAC_BITS  = 0,
    parameter int TAG_BITS   = 1
);
    localparam int RW = INPUT_BITS + (INPUT_BITS % 2) + 2 * FRAC_BITS;
    localparam int N  = RW / 2;

    logic                  in_valid;
    logic                  in_ready;
    logic [INPUT_BITS-1:0] radicand;
    logic [TAG_BITS-1:0]   in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          root;
    logic [N:0]            remainder;
    logic [TAG_BITS-1:0]   out_tag;

    modport master (
        output in_valid, radicand, in_tag, out_ready,
        input  in_ready, out_valid, root, remainder, out_tag
    );

    modport slave (
        input  in_valid, radicand, in_tag, out_ready,
        output in_ready, out_valid, root, remainder, out_tag
    );
endinterface

// File: rtl/sqrt_pipelined_hs.sv
// sqrt_pipelined_hs: N-stage digit-by-digit fixed-point square root
// with global-stall valid/ready. Define SQRT_ROUND_EN to round the root.
module sqrt_pipelined_hs #(
    parameter int INPUT_BITS = 16,
    parameter int FRAC_BITS  = 0,
    parameter int TAG_BITS   = 1
) (
    input logic                clk,
    input logic                reset_n,
    sqrt_pipelined_hs_if.slave bus
);
    localparam int RW  = INPUT_BITS + (INPUT_BITS % 2) + 2 * FRAC_BITS;
    localparam int N   = RW / 2;
    localparam int RMW = N + 2;

    logic                vld_q  [N];
    logic [RW-1:0]       rad_q  [N];
    logic [N-1:0]        root_q [N];
    logic [RMW-1:0]      rem_q  [N];
    logic [TAG_BITS-1:0] tag_q  [N];

    logic                vld_d  [N];
    logic [RW-1:0]       rad_d  [N];
    logic [N-1:0]        root_d [N];
    logic [RMW-1:0]      rem_d  [N];
    logic [TAG_BITS-1:0] tag_d  [N];

    logic                src_vld  [N];
    logic [RW-1:0]       src_rad  [N];
    logic [N-1:0]        src_root [N];
    logic [N-1:0]        src_rem  [N];
    logic [TAG_BITS-1:0] src_tag  [N];

    logic          advance;
    logic [RW-1:0] rad_ext;
    logic          unused_bits;

    assign advance      = !vld_q[N-1] || bus.out_ready;
    assign bus.in_ready = advance;
    assign rad_ext      = RW'(bus.radicand) << (2 * FRAC_BITS);

    assign bus.out_valid = vld_q[N-1];
    assign bus.root      = root_q[N-1];
    assign bus.remainder = rem_q[N-1][N:0];
    assign bus.out_tag   = tag_q[N-1];

    assign unused_bits = ^{rad_q[N-1], rem_q[N-1][N+1]};

    // Stage sources: stage 1 from the inputs, later stages from the
    // previous register. Remainders entering any stage fit in N bits.
    always_comb begin
        src_vld[0]  = bus.in_valid;
        src_rad[0]  = rad_ext;
        src_root[0] = '0;
        src_rem[0]  = '0;
        src_tag[0]  = bus.in_tag;
        for (int k = 1; k < N; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_rad[k]  = rad_q[k-1];
            src_root[k] = root_q[k-1];
            src_rem[k]  = rem_q[k-1][N-1:0];
            src_tag[k]  = tag_q[k-1];
        end
    end

    // One root digit per stage; the last stage optionally rounds.
    always_comb begin
        logic [RMW-1:0] cur;
        logic [RMW-1:0] trial;
        logic           take;
        for (int k = 0; k < N; k++) begin
            cur   = {src_rem[k], src_rad[k][RW-1 -: 2]};
            trial = {src_root[k], 2'b01};
            take  = (trial <= cur);
            vld_d[k]  = src_vld[k];
            tag_d[k]  = src_tag[k];
            rad_d[k]  = src_rad[k] << 2;
            rem_d[k]  = take ? (cur - trial) : cur;
            root_d[k] = N'({src_root[k], take});
        end
`ifdef SQRT_ROUND_EN
        if ((rem_d[N-1] > RMW'(root_d[N-1])) && !(&root_d[N-1]))
            root_d[N-1] = root_d[N-1] + N'(1);
`endif
    end

    // Global stall: all stages move together; bubbles keep old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                vld_q[k]  <= 1'b0;
                rad_q[k]  <= '0;
                root_q[k] <= '0;
                rem_q[k]  <= '0;
                tag_q[k]  <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < N; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    rad_q[k]  <= rad_d[k];
                    root_q[k] <= root_d[k];
                    rem_q[k]  <= rem_d[k];
                    tag_q[k]  <= tag_d[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_sqrt_pipelined_hs.sv
// tb_sqrt_pipelined_hs: random and directed checks of the pipelined
// square root against an arithmetic floor-sqrt reference.
module tb_sqrt_pipelined_hs;
    localparam int N  = 8;
    localparam int NF = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    sqrt_pipelined_hs_if #(
        .INPUT_BITS(16), .FRAC_BITS(0), .TAG_BITS(4)
    ) bus ();
    sqrt_pipelined_hs_if #(
        .INPUT_BITS(16), .FRAC_BITS(4), .TAG_BITS(4)
    ) bus_f ();

    sqrt_pipelined_hs #(
        .INPUT_BITS(16), .FRAC_BITS(0), .TAG_BITS(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    sqrt_pipelined_hs #(
        .INPUT_BITS(16), .FRAC_BITS(4), .TAG_BITS(4)
    ) u_frac (
        .clk(clk), .reset_n(reset_n), .bus(bus_f)
    );

    typedef struct {
        longint unsigned root;
        longint unsigned rem;
        logic [3:0]      tag;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic       s_ret, s_valid, s_ready, s_adv;
    logic [7:0] s_root;
    logic [8:0] s_rem;
    logic [3:0] s_tag;

    function automatic longint unsigned isqrt(longint unsigned x);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic exp_t model(longint unsigned x, int nb,
                                   logic [3:0] tag, int c);
        exp_t e;
        e.root = isqrt(x);
        e.rem  = x - e.root * e.root;
`ifdef SQRT_ROUND_EN
        if (e.rem > e.root && e.root < (64'd1 << nb) - 1)
            e.root = e.root + 1;
`endif
        e.tag = tag;
        e.cyc = c;
        return e;
    endfunction

    // Drive one cycle at the falling edge and sample just after it.
    task automatic tick(input logic v, input logic [15:0] rad,
                        input logic [3:0] tag, input logic ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.radicand  = rad;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        cyc++;
        s_valid = bus.out_valid;
        s_ready = bus.in_ready;
        s_adv   = !bus.out_valid || ordy;
        s_ret   = bus.out_valid && ordy;
        s_root  = bus.root;
        s_rem   = bus.remainder;
        s_tag   = bus.out_tag;
        if (v && bus.in_ready) q.push_back(model(rad, N, tag, cyc));
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.root !== 8'd0 || bus.remainder !== 9'd0) begin
            bad++;
            $display("FAIL rst_data root=%0d rem=%0d want 0 0",
                     bus.root, bus.remainder);
        end
        total++;
        if (bus.out_tag !== 4'd0) begin
            bad++;
            $display("FAIL rst_tag got=%0d want=0", bus.out_tag);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus_f.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_frac_valid got=%b want=0", bus_f.out_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rads [3];
        int got = 0;
        exp_t e;
        rads = '{16'd144, 16'd65535, 16'd0};
        q.delete();
        for (int i = 0; i < 3; i++) tick(1'b1, rads[i], 4'(i + 1), 1'b1);
        for (int i = 0; i < 3 * N && got < 3; i++) begin
            tick(1'b0, 16'd0, 4'd0, 1'b1);
            if (s_ret) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra root=%0d want none", s_root);
                end else begin
                    e = q.pop_front();
                    if (s_root !== 8'(e.root) || s_rem !== 9'(e.rem) ||
                        s_tag !== e.tag) begin
                        bad++;
                        $display("FAIL b2b_data got %0d/%0d/%0d want %0d/%0d/%0d",
                                 s_root, s_rem, s_tag, e.root, e.rem, e.tag);
                    end
                    total++;
                    if (cyc - e.cyc != N) begin
                        bad++;
                        $display("FAIL b2b_latency got=%0d want=%0d",
                                 cyc - e.cyc, N);
                    end
                end
                got++;
            end
        end
        total++;
        if (got != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=3", got);
        end
    endtask

    task automatic test_frac();
        logic [15:0] rads [2];
        int got = 0;
        exp_t e;
        rads = '{16'd2, 16'd65535};
        @(negedge clk);
        bus_f.in_valid = 1'b1;
        bus_f.radicand = rads[0];
        bus_f.in_tag   = 4'd5;
        @(negedge clk);
        bus_f.radicand = rads[1];
        bus_f.in_tag   = 4'd6;
        @(negedge clk);
        bus_f.in_valid = 1'b0;
        for (int i = 0; i < 3 * NF && got < 2; i++) begin
            #1;
            if (bus_f.out_valid) begin
                e = model(longint'(rads[got]) << 8, NF, 4'(5 + got), 0);
                total++;
                if (bus_f.root !== 12'(e.root) ||
                    bus_f.remainder !== 13'(e.rem) ||
                    bus_f.out_tag !== e.tag) begin
                    bad++;
                    $display("FAIL frac_data got %0d/%0d/%0d want %0d/%0d/%0d",
                             bus_f.root, bus_f.remainder, bus_f.out_tag,
                             e.root, e.rem, e.tag);
                end
                if (got == 0) begin
                    total++;
`ifdef SQRT_ROUND_EN
                    if (bus_f.root !== 12'd23 || bus_f.remainder !== 13'd28) begin
`else
                    if (bus_f.root !== 12'd22 || bus_f.remainder !== 13'd28) begin
`endif
                        bad++;
                        $display("FAIL frac_two got %0d/%0d want 22or23/28",
                                 bus_f.root, bus_f.remainder);
                    end
                end
                got++;
            end
            @(negedge clk);
        end
        total++;
        if (got != 2) begin
            bad++;
            $display("FAIL frac_count got=%0d want=2", got);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int ret = 0;
        logic v, ordy, pstall;
        logic [15:0] rad;
        logic [3:0] tag;
        logic [21:0] prev;
        exp_t e;
        q.delete();
        pstall = 1'b0;
        prev = '0;
        tag = 4'd0;
        rad = 16'($urandom_range(65535, 0));
        for (int c = 0; c < 400 && ret < 20; c++) begin
            ordy = (c % 5) >= 3;
            v = (acc < 20);
            tick(v, rad, tag, ordy);
            total++;
            if (s_ready !== s_adv) begin
                bad++;
                $display("FAIL bp_ready cyc=%0d got=%b want=%b",
                         c, s_ready, s_adv);
            end
            if (pstall) begin
                total++;
                if ({s_valid, s_root, s_rem, s_tag} !== prev) begin
                    bad++;
                    $display("FAIL bp_hold cyc=%0d got=%h want=%h",
                             c, {s_valid, s_root, s_rem, s_tag}, prev);
                end
            end
            if (v && s_ready) begin
                acc++;
                tag = tag + 4'd1;
                rad = 16'($urandom_range(65535, 0));
            end
            if (s_ret) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra root=%0d want none", s_root);
                end else begin
                    e = q.pop_front();
                    if (s_root !== 8'(e.root) || s_rem !== 9'(e.rem) ||
                        s_tag !== e.tag) begin
                        bad++;
                        $display("FAIL bp_data got %0d/%0d/%0d want %0d/%0d/%0d",
                                 s_root, s_rem, s_tag, e.root, e.rem, e.tag);
                    end
                end
                ret++;
            end
            pstall = s_valid && !ordy;
            prev = {s_valid, s_root, s_rem, s_tag};
        end
        total++;
        if (ret != 20 || acc != 20 || q.size() != 0) begin
            bad++;
            $display("FAIL bp_count got acc=%0d ret=%0d left=%0d want 20 20 0",
                     acc, ret, q.size());
        end
    endtask

    task automatic test_bubbles();
        logic pat [5];
        logic obs [5 + N + 2];
        exp_t e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        q.delete();
        for (int i = 0; i < 5 + N + 2; i++) begin
            if (i < 5)
                tick(pat[i], 16'($urandom_range(65535, 0)), 4'(i), 1'b1);
            else
                tick(1'b0, 16'd0, 4'd0, 1'b1);
            obs[i] = s_valid;
            if (s_ret && q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (s_root !== 8'(e.root) || s_rem !== 9'(e.rem) ||
                    s_tag !== e.tag) begin
                    bad++;
                    $display("FAIL bub_data got %0d/%0d/%0d want %0d/%0d/%0d",
                             s_root, s_rem, s_tag, e.root, e.rem, e.tag);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs[i + N] !== pat[i]) begin
                bad++;
                $display("FAIL bub_valid idx=%0d got=%b want=%b",
                         i, obs[i + N], pat[i]);
            end
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== 1'b0) begin
                bad++;
                $display("FAIL bub_early idx=%0d got=%b want=0", i, obs[i]);
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL bub_left got=%0d want=0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [15:0] rad;
        q.delete();
        for (int i = 0; i < N + 2; i++) begin
            tick(1'b1, 16'($urandom_range(65535, 0)), 4'(i), 1'b1);
            if (s_ret && q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (s_root !== 8'(e.root) || s_rem !== 9'(e.rem)) begin
                    bad++;
                    $display("FAIL rm_pre got %0d/%0d want %0d/%0d",
                             s_root, s_rem, e.root, e.rem);
                end
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rm_inflight got=%b want=1", bus.out_valid);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.root !== 8'd0 ||
            bus.remainder !== 9'd0 || bus.out_tag !== 4'd0) begin
            bad++;
            $display("FAIL rm_async got v=%b r=%0d m=%0d t=%0d want 0",
                     bus.out_valid, bus.root, bus.remainder, bus.out_tag);
        end
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'd0, 4'd0, 1'b1);
            total++;
            if (s_valid !== 1'b0) begin
                bad++;
                $display("FAIL rm_idle idx=%0d got=%b want=0", i, s_valid);
            end
        end
        rad = 16'($urandom_range(65535, 0));
        tick(1'b1, rad, 4'd9, 1'b1);
        for (int i = 1; i <= N; i++) begin
            tick(1'b0, 16'd0, 4'd0, 1'b1);
            total++;
            if (s_valid !== (i == N)) begin
                bad++;
                $display("FAIL rm_wait idx=%0d got=%b want=%b",
                         i, s_valid, (i == N));
            end
        end
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL rm_post got none want one");
        end else begin
            e = q.pop_front();
            if (s_root !== 8'(e.root) || s_rem !== 9'(e.rem) ||
                s_tag !== e.tag) begin
                bad++;
                $display("FAIL rm_post got %0d/%0d/%0d want %0d/%0d/%0d",
                         s_root, s_rem, s_tag, e.root, e.rem, e.tag);
            end
        end
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.radicand    = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;
        bus_f.in_valid  = 1'b0;
        bus_f.radicand  = '0;
        bus_f.in_tag    = '0;
        bus_f.out_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_frac();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d",
                 total, bad);
        $fatal(1, "time limit");
    end
endmodule
